// File: rtl/bvf_stream_decoder.sv
// Streaming pairwise-BVF decoder: out[2k]=in[2k], out[2k+1]=in[2k+1]^in[2k].
// Accepted words are decoded, tagged with their frame index and held in a 2-entry FIFO.
module bvf_stream_decoder #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [IDX_W-1:0]  m_index,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  // Handshake: a beat transfers on a rising edge where valid && ready. s_ready
  // depends only on occupancy (and reset), never on m_ready, so no s-to-m path.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] r_mem_data [2];
  logic [IDX_W-1:0]  r_mem_idx  [2];
  logic [1:0]        r_mem_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [IDX_W-1:0]  r_wr_idx;
  logic              r_frame_err;
  logic [15:0]       r_frame_count;

  logic              w_push;
  logic              w_pop;
  logic              w_idx_at_end;
  logic [DATA_W-1:0] w_decoded;

  always_comb begin
    w_decoded = s_data;
    for (int k = 0; k < DATA_W / 2; k++) begin
      w_decoded[2*k+1] = s_data[2*k+1] ^ s_data[2*k];
    end
  end

  assign s_ready      = rst_n && (r_count != 2'd2);
  assign m_valid      = (r_count != 2'd0);
  assign m_data       = r_mem_data[r_rd_ptr];
  assign m_last       = r_mem_last[r_rd_ptr];
  assign m_index      = r_mem_idx[r_rd_ptr];
  assign frame_err    = r_frame_err;
  assign frame_count  = r_frame_count;

  assign w_push       = s_valid && s_ready;
  assign w_pop        = m_valid && m_ready;
  assign w_idx_at_end = (r_wr_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Storage is cleared too so the head reads as zero while empty.
      for (int i = 0; i < 2; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
      r_mem_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_wr_idx      <= '0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_decoded;
        r_mem_last[r_wr_ptr] <= s_last;
        r_mem_idx[r_wr_ptr]  <= r_wr_idx;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (w_push) begin
        // Frame boundary either from s_last or from the length limit; a
        // disagreement between the two is a short or long frame.
        if (s_last || w_idx_at_end) begin
          r_wr_idx <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
        if (s_last != w_idx_at_end) begin
          r_frame_err <= 1'b1;
        end
        if (s_last && (r_frame_count != 16'hFFFF)) begin
          r_frame_count <= r_frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bvf_stream_decoder.sv
// Randomized bench for bvf_stream_decoder against a queue-based reference model.
module tb_bvf_stream_decoder;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 2;
  localparam int W         = DATA_W + 1 + IDX_W;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [IDX_W-1:0]  m_index;
  logic              frame_err;
  logic [15:0]       frame_count;

  bvf_stream_decoder #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_index(m_index), .frame_err(frame_err), .frame_count(frame_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard: expected {data, last, index} in output order
  logic [W-1:0]      exp_q[$];
  logic [DATA_W:0]   send_q[$];   // {last, encoded data} awaiting the driver
  int                m_pos;
  logic              m_err;
  int                m_cnt;
  logic              acc;
  int                gen_pos;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: each 2-bit pair (hi,lo) becomes (hi xor lo, lo).
  function automatic logic [DATA_W-1:0] ref_decode(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    int pair;
    y = '0;
    for (int k = 0; k < DATA_W / 2; k++) begin
      pair = int'(x[2*k +: 2]);
      case (pair)
        0: y[2*k +: 2] = 2'b00;
        1: y[2*k +: 2] = 2'b11;
        2: y[2*k +: 2] = 2'b10;
        default: y[2*k +: 2] = 2'b01;
      endcase
    end
    return y;
  endfunction

  task automatic model_push(input logic [DATA_W-1:0] d, input logic last);
    logic at_end;
    at_end = (m_pos == FRAME_LEN - 1);
    exp_q.push_back({ref_decode(d), last, IDX_W'(m_pos)});
    if (last != at_end) m_err = 1'b1;
    if (last && m_cnt < 65535) m_cnt++;
    m_pos = (last || at_end) ? 0 : m_pos + 1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pos = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // driver: one clock of stimulus plus checks at negedge+1
  task automatic step(input logic mr);
    logic [W-1:0] e;
    @(negedge clk);
    if (acc) begin
      s_valid = 1'b0;
      acc = 1'b0;
    end
    if (!s_valid && send_q.size() > 0) begin
      {s_last, s_data} = send_q.pop_front();
      s_valid = 1'b1;
    end
    m_ready = mr;
    #1;
    chk("s_ready", s_ready, exp_q.size() < 2);
    chk("m_valid", m_valid, exp_q.size() > 0);
    chk("frame_err", frame_err, m_err);
    chk("frame_count", frame_count, m_cnt);
    if (m_valid && m_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m_data", m_data, e[W-1 -: DATA_W]);
      chk("m_last", m_last, e[IDX_W]);
      chk("m_index", m_index, e[IDX_W-1:0]);
    end
    if (s_valid && s_ready) begin
      model_push(s_data, s_last);
      acc = 1'b1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    send_q.push_back({last, d});
  endtask

  task automatic run(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(mr);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (send_q.size() > 0 || (s_valid && !acc) || exp_q.size() > 0); i++)
      step(1'b1);
    step(1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    acc = 1'b0;
    m_ready = 1'b0;
    send_q.delete();
    #1;
    chk("s_ready_in_reset", s_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    gen_pos = 0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_index", m_index, 0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_s_ready", s_ready, 1'b1);
  endtask

  initial begin
    logic last;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    acc = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // single words, latency 1: A5->AF, FF->55, 00->00, then close the frame
    send(8'hA5, 1'b0);
    step(1'b1);
    step(1'b1);
    chk("single_a5", m_data, 8'hAF);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'h3C, 1'b1);
    drain();

    // full frame streaming
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    drain();

    // backpressure: three words against a stalled consumer
    send(8'h5A, 1'b0); send(8'hC3, 1'b0); send(8'h96, 1'b0);
    run(5, 1'b0);
    send(8'h0F, 1'b1);
    drain();

    // short frame, then a clean frame starting at index 0
    send(8'h12, 1'b0); send(8'h34, 1'b1);
    send(8'h56, 1'b0); send(8'h78, 1'b0); send(8'h9A, 1'b0); send(8'hBC, 1'b1);
    drain();

    // long frame after a fresh reset
    do_reset();
    for (int i = 0; i < 5; i++) send(DATA_W'($urandom_range(0, 255)), 1'b0);
    send(8'hE1, 1'b0); send(8'hD2, 1'b1);
    drain();

    // reset with two words buffered, then a word must come out tagged index 0
    do_reset();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    run(4, 1'b0);
    do_reset();
    send(8'hCC, 1'b1);
    drain();

    // randomized traffic with occasional framing errors
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (send_q.size() < 2 && $urandom_range(0, 3) != 0) begin
        last = (gen_pos == FRAME_LEN - 1);
        if ($urandom_range(0, 19) == 0) last = ~last;
        send(DATA_W'($urandom_range(0, 255)), last);
        gen_pos = (last || gen_pos == FRAME_LEN - 1) ? 0 : gen_pos + 1;
      end
      step($urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
